// File: rtl/fwd_hazard_unit.sv
// Forwarding select and load-use hazard controller for a 5-stage RISC-V pipeline.
// Define HAZARD_STALL_EN to build in load-use stall, bubble-on-stall and the stall counter.

module fwd_sel #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] ex_mem_rd_i,
  input  logic              ex_mem_rw_i,
  input  logic              ex_mem_mr_i,
  input  logic [REG_AW-1:0] mem_wb_rd_i,
  input  logic              mem_wb_rw_i,
  output logic [1:0]        sel_o
);
  logic ex_hit, wb_hit;

  // A load still in EX/MEM has no data yet, so it may only match from MEM/WB.
  assign ex_hit = ex_mem_rw_i && (ex_mem_rd_i != '0) && (ex_mem_rd_i == rs_i) && !ex_mem_mr_i;
  assign wb_hit = mem_wb_rw_i && (mem_wb_rd_i != '0) && (mem_wb_rd_i == rs_i);

  always_comb begin
    sel_o = 2'b00;
    if (ex_hit)      sel_o = 2'b10;
    else if (wb_hit) sel_o = 2'b01;
  end
endmodule

module fwd_hazard_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  localparam int NOPS = 2;

  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } id_ex_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
  } ex_mem_t;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              regwrite;
  } mem_wb_t;

  id_ex_t  id_ex_q,  id_ex_d;
  ex_mem_t ex_mem_q, ex_mem_d;
  mem_wb_t mem_wb_q, mem_wb_d;

  logic                         bubble;
  logic [NOPS-1:0][REG_AW-1:0]  op_rs;
  logic [NOPS-1:0][1:0]         op_sel;

  assign op_rs[0] = id_ex_q.rs1;
  assign op_rs[1] = id_ex_q.rs2;

  for (genvar g = 0; g < NOPS; g++) begin : g_op
    fwd_sel #(.REG_AW(REG_AW)) u_sel (
      .rs_i        (op_rs[g]),
      .ex_mem_rd_i (ex_mem_q.rd),
      .ex_mem_rw_i (ex_mem_q.regwrite),
      .ex_mem_mr_i (ex_mem_q.memread),
      .mem_wb_rd_i (mem_wb_q.rd),
      .mem_wb_rw_i (mem_wb_q.regwrite),
      .sel_o       (op_sel[g])
    );
  end

  assign fwd_a_o = op_sel[0];
  assign fwd_b_o = op_sel[1];

`ifdef HAZARD_STALL_EN
  logic             load_use;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  assign load_use = id_ex_q.memread && (id_ex_q.rd != '0) &&
                    ((id_ex_q.rd == id_rs1_i) || (id_ex_q.rd == id_rs2_i));
  assign stall_o  = load_use;
  assign bubble   = load_use || flush_i;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (load_use) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_o     = 1'b0;
  assign stall_cnt_o = '0;
  assign bubble      = flush_i;
`endif

  always_comb begin
    id_ex_d = '{rs1: id_rs1_i, rs2: id_rs2_i, rd: id_rd_i,
                regwrite: id_regwrite_i, memread: id_memread_i};
    if (bubble) id_ex_d = '0;
    ex_mem_d = '{rd: id_ex_q.rd, regwrite: id_ex_q.regwrite, memread: id_ex_q.memread};
    mem_wb_d = '{rd: ex_mem_q.rd, regwrite: ex_mem_q.regwrite};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: per-cycle model compare plus literal checkpoints.
module tb_fwd_hazard_unit;
`ifdef HAZARD_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1 = '0, rs2 = '0, rd = '0;
  logic        rw = 1'b0, mr = 1'b0, fl = 1'b0;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall;
  logic [31:0] stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  fwd_hazard_unit #(.REG_AW(5), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_rd_i(rd),
    .id_regwrite_i(rw), .id_memread_i(mr), .flush_i(fl),
    .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .stall_o(stall), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the last three instructions to enter EX, newest first.
  typedef struct { int rs1; int rs2; int rd; bit rw; bit mr; } ins_t;
  ins_t        hist [3];
  int unsigned m_cnt;
  bit          cmp_on = 1'b0;

  function automatic bit m_stall();
    return STALL_EN && hist[0].mr && hist[0].rd != 0 &&
           (hist[0].rd == int'(rs1) || hist[0].rd == int'(rs2));
  endfunction

  // Newest result available wins; a load one step ahead has no data yet.
  function automatic logic [1:0] m_fwd(input int rs);
    if (rs == 0) return 2'b00;
    if (hist[1].rw && hist[1].rd == rs && !hist[1].mr) return 2'b10;
    if (hist[2].rw && hist[2].rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    bit   st;
    ins_t nxt;
    st  = m_stall();
    nxt = '{int'(rs1), int'(rs2), int'(rd), rw, mr};
    if (st || fl) nxt = '{0, 0, 0, 1'b0, 1'b0};
    if (rst) begin
      for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 1'b0, 1'b0};
      m_cnt = 0;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = nxt;
      if (st) m_cnt = m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_fwd_a", {30'd0, fwd_a}, {30'd0, m_fwd(hist[0].rs1)});
      chk("model_fwd_b", {30'd0, fwd_b}, {30'd0, m_fwd(hist[0].rs2)});
      chk("model_stall", {31'd0, stall}, {31'd0, m_stall()});
      chk("model_cnt", stall_cnt, m_cnt);
    end
  end

  // Present one instruction in ID until it is accepted, then leave a nop in ID.
  task automatic issue(input int a, input int b, input int d, input bit w, input bit m,
                       input bit f = 1'b0);
    bit st;
    int g;
    g = 0;
    rs1 = 5'(a); rs2 = 5'(b); rd = 5'(d); rw = w; mr = m; fl = f;
    do begin
      @(negedge clk);
      st = m_stall();
      @(posedge clk);
      #1;
      g++;
    end while (st && g < 4);
    if (st) begin
      n_cmp++; n_bad++;
      $display("FAIL stall_bound: still stalled after %0d cycles", g);
    end
    rs1 = '0; rs2 = '0; rd = '0; rw = 1'b0; mr = 1'b0; fl = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 1'b0, 1'b0};
    m_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_on = 1'b1;
    #2;
    chk("reset_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("reset_fwd_b", {30'd0, fwd_b}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_cnt", stall_cnt, 32'd0);

    // add x5 ; sub x10,x5,x3
    issue(0, 0, 5, 1, 0);
    issue(5, 3, 10, 1, 0);
    #2;
    chk("b2b_fwd_a", {30'd0, fwd_a}, 32'd2);
    chk("b2b_fwd_b", {30'd0, fwd_b}, 32'd0);

    // addi x6 ; unrelated ; or x12,x4,x6
    issue(1, 2, 6, 1, 0);
    issue(1, 1, 11, 1, 0);
    issue(4, 6, 12, 1, 0);
    #2;
    chk("dist2_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("dist2_fwd_b", {30'd0, fwd_b}, 32'd1);

    // addi x7,1 ; addi x7,2 ; add x8,x7,x7
    issue(0, 0, 7, 1, 0);
    issue(7, 0, 7, 1, 0);
    issue(7, 7, 8, 1, 0);
    #2;
    chk("dbl_fwd_a", {30'd0, fwd_a}, 32'd2);
    chk("dbl_fwd_b", {30'd0, fwd_b}, 32'd2);

    // lw x9 ; add x13,x9,x2
    issue(1, 0, 9, 1, 1);
    rs1 = 5'd9; rs2 = 5'd2; rd = 5'd13; rw = 1'b1;
    #2;
    chk("lu_stall", {31'd0, stall}, {31'd0, STALL_EN});
    chk("lu_cnt_before", stall_cnt, 32'd0);
    issue(9, 2, 13, 1, 0);
    #2;
    chk("lu_fwd_a", {30'd0, fwd_a}, STALL_EN ? 32'd1 : 32'd0);
    chk("lu_stall_clear", {31'd0, stall}, 32'd0);
    chk("lu_cnt_after", stall_cnt, STALL_EN ? 32'd1 : 32'd0);

    // rd=x0 producer, consumer of x0
    issue(0, 0, 0, 1, 0);
    issue(0, 0, 14, 1, 0);
    #2;
    chk("x0_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("x0_fwd_b", {30'd0, fwd_b}, 32'd0);

    // flushed lw x9, then a consumer of x9
    issue(1, 0, 9, 1, 1, 1);
    rs1 = 5'd9; rs2 = 5'd9;
    #2;
    chk("flush_no_stall", {31'd0, stall}, 32'd0);
    issue(9, 9, 15, 1, 0);
    #2;
    chk("flush_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("flush_fwd_b", {30'd0, fwd_b}, 32'd0);

    // stall coincident with flush: one bubble, counter still steps
    issue(1, 0, 9, 1, 1);
    issue(9, 0, 16, 1, 0, 1);
    #2;
    chk("sf_cnt", stall_cnt, STALL_EN ? 32'd2 : 32'd0);

    // mixed traffic over a small register window
    for (int i = 0; i < 60; i++)
      issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);

    // reset with x5 producer live in EX/MEM
    issue(0, 0, 5, 1, 0);
    issue(1, 2, 3, 1, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    #2;
    chk("rst_cnt", stall_cnt, 32'd0);
    issue(5, 5, 17, 1, 0);
    #2;
    chk("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
    chk("rst_fwd_b", {30'd0, fwd_b}, 32'd0);

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Forwarding and load-use hazard controller for the 5-stage RISC-V pipeline. It tracks destination-register metadata through ID/EX, EX/MEM and MEM/WB in its own shadow pipeline. From that state it generates the 2-bit select codes for the two EX-stage operand forwarding muxes (rs1 and rs2 paths). With hazard detection compiled in, it also raises a one-cycle stall and inserts a bubble on load-use dependencies.

## Interface
Parameters:
- REG_AW, 5, register index width.
- CNT_W, 32, stall counter width.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- id_rs1_i  input  REG_AW  rs1 of the instruction in ID.
- id_rs2_i  input  REG_AW  rs2 of the instruction in ID.
- id_rd_i  input  REG_AW  rd of the instruction in ID.
- id_regwrite_i  input  1  ID instruction writes rd.
- id_memread_i  input  1  ID instruction is a load.
- flush_i  input  1  branch/jump taken; squash the instruction leaving ID.
- fwd_a_o  output  2  rs1 operand mux select.
- fwd_b_o  output  2  rs2 operand mux select.
- stall_o  output  1  hold PC and IF/ID; bubble into ID/EX.
- stall_cnt_o  output  CNT_W  number of stall cycles since reset.

## Operation
- Internal shadow registers:
  - ID/EX holds {rs1, rs2, rd, regwrite, memread}.
  - EX/MEM holds {rd, regwrite, memread}.
  - MEM/WB holds {rd, regwrite}.
- Every cycle the shadow pipeline advances: MEM/WB <= EX/MEM, EX/MEM <= ID/EX, and ID/EX <= ID inputs.
- Bubble: if stall_o=1 or flush_i=1, ID/EX loads rs1=rs2=rd=0 and regwrite=memread=0 in place of the ID inputs. EX/MEM and MEM/WB still advance.
- Select encoding: 00 selects the ID/EX register-file value, 01 the MEM/WB writeback data, 10 the EX/MEM ALU result. 11 is never driven.
- fwd_a_o is derived from ID/EX.rs1, and fwd_b_o identically from ID/EX.rs2. For each operand, in priority order:
  - EX/MEM.regwrite, EX/MEM.rd≠0, EX/MEM.rd==rs, EX/MEM.memread=0 → 10.
  - Otherwise MEM/WB.regwrite, MEM/WB.rd≠0, MEM/WB.rd==rs → 01.
  - Otherwise 00.
- x0 is never forwarded.
- A load held in EX/MEM never selects 10; matching falls through to the MEM/WB check.
- Load-use hazard: ID/EX.memread=1, ID/EX.rd≠0, and (ID/EX.rd==id_rs1_i or ID/EX.rd==id_rs2_i).
- stall_o is asserted combinationally while the hazard holds. The ID/EX bubble guarantees the hazard clears the next cycle, so a stall lasts exactly 1 cycle.
- flush_i and stall_o together: the bubble is inserted once; stall_cnt_o still increments.
- stall_cnt_o increments on each rising edge with stall_o=1 and wraps modulo 2^CNT_W.

## Timing
- fwd_a_o, fwd_b_o and stall_o are combinational from shadow state and ID inputs, valid in the same cycle. The forwarding path has no added latency.
- All shadow state updates on the rising edge of clk_i.
- Reset: when rst_i=1 at a rising edge, all shadow fields clear to 0 and stall_cnt_o clears to 0. Consequently fwd_a_o=fwd_b_o=00 and stall_o=0 in the following cycle.
- Reset mid-operation discards all in-flight metadata. No forwarding occurs from pre-reset instructions.
- rst_i takes priority over flush_i and the stall logic.
- A producer in ID at cycle N is forwarded:
  - from EX/MEM (10) to a consumer that is in EX at cycle N+2;
  - from MEM/WB (01) to a consumer in EX at cycle N+3.

## Configuration
- HAZARD_STALL_EN defined: load-use detection, stall_o, ID/EX bubble-on-stall and stall_cnt_o are all active as described.
- HAZARD_STALL_EN undefined:
  - stall_o is tied 0 and stall_cnt_o is tied 0.
  - Only flush_i inserts bubbles.
  - The compiler/software is responsible for load-use nops.
  - Forwarding logic is unchanged, including the rule that a load in EX/MEM never selects 10.

## Test plan
- Back-to-back dependency: `add x5` then `sub` using rs1=x5 → fwd_a_o=10 when the sub is in EX, fwd_b_o=00.
- Distance-2 dependency: `addi x6`, one unrelated instr, then `or` using rs2=x6 → fwd_b_o=01 when the or is in EX.
- Double hazard: `addi x7,1`; `addi x7,2`; `add x8,x7,x7` → fwd_a_o=fwd_b_o=10, i.e. the newest producer wins.
- Load-use: `lw x9` followed by `add` reading x9 → stall_o=1 for exactly 1 cycle and stall_cnt_o goes 0→1; the add then sees fwd_a_o=01.
- x0 and flush:
  - Producer with rd=x0 followed by a consumer reading x0 → fwd=00.
  - flush_i=1 on a `lw x9` leaving ID, followed by a consumer reading x9 → no stall, fwd=00.
- Reset mid-stream: assert rst_i for 1 cycle with a live EX/MEM producer of x5 → the next consumer of x5 gets fwd=00, stall_cnt_o=0. Without HAZARD_STALL_EN the load-use case gives stall_o=0.
